// File: rtl/seq_mem_d1_initiator.sv
// rtl/seq_mem_d1_initiator.sv - command-driven master for a single-port sequential memory
//
// Takes read, write and fill commands on a valid/ready channel and runs them
// on the memory port one access at a time. Read data and write completions
// come back on a valid/ready response channel.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_op            00 read, 01 write, 10 fill, 11 reserved (rejected)
//   cmd_addr          start address
//   cmd_len           beats minus one (read/fill; write is always one beat)
//   cmd_data          write/fill data
//   rsp_valid/ready   response handshake
//   rsp_data          read word; 0 for write/fill/error responses
//   rsp_last          final response of a command
//   rsp_err           command rejected
//   busy              FSM not idle
//   mem_*             seq_mem port (addr0, read_en, write_en, in, out, done strobes)
module seq_mem_d1_initiator #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_SIZE-1:0] cmd_addr,
  input  logic [IDX_SIZE-1:0] cmd_len,
  input  logic [WIDTH-1:0]    cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_last,
  output logic                rsp_err,
  output logic                busy,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_in,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  input  logic                mem_write_done
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_RSP, WR_ISSUE, WR_WAIT, WR_RSP, ERR_RSP
  } state_t;

  localparam logic [IDX_SIZE:0] SIZE_LIM = (IDX_SIZE+1)'(SIZE);

  state_t              state;
  logic [IDX_SIZE-1:0] addr_q;
  logic [IDX_SIZE-1:0] len_q;
  logic [IDX_SIZE-1:0] beat_q;

  logic [IDX_SIZE-1:0] len_eff;
  logic [IDX_SIZE:0]   end_addr;
  logic                reject;

  // The end address is computed one bit wider so an out-of-range burst is
  // seen as such instead of wrapping; such bursts are rejected whole.
  always_comb begin
    len_eff  = (cmd_op == 2'b01) ? '0 : cmd_len;
    end_addr = {1'b0, cmd_addr} + {1'b0, len_eff};
    reject   = (cmd_op == 2'b11) || (end_addr >= SIZE_LIM);
  end

  // Gated with reset so the command channel is closed during the reset cycle.
  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_last     <= 1'b0;
      rsp_err      <= 1'b0;
      mem_addr0    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_in       <= '0;
    end else begin
      // Strobes are single-cycle; they are raised only on entry to an ISSUE state.
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= len_eff;
            beat_q <= '0;
            if (reject) begin
              state     <= ERR_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_data  <= '0;
            end else if (cmd_op == 2'b00) begin
              state       <= RD_ISSUE;
              mem_read_en <= 1'b1;
              mem_addr0   <= cmd_addr;
            end else begin
              state        <= WR_ISSUE;
              mem_write_en <= 1'b1;
              mem_addr0    <= cmd_addr;
              mem_in       <= cmd_data;
            end
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          // mem_out is only trusted on done: a write clobbers it.
          if (mem_read_done) begin
            rsp_data  <= mem_out;
            rsp_last  <= (beat_q == len_q);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              addr_q      <= addr_q + IDX_SIZE'(1);
              beat_q      <= beat_q + IDX_SIZE'(1);
              mem_addr0   <= addr_q + IDX_SIZE'(1);
              mem_read_en <= 1'b1;
              state       <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE: state <= WR_WAIT;
        WR_WAIT: begin
          if (mem_write_done) begin
            if (beat_q == len_q) begin
              state     <= WR_RSP;
              rsp_valid <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= '0;
            end else begin
              addr_q       <= addr_q + IDX_SIZE'(1);
              beat_q       <= beat_q + IDX_SIZE'(1);
              mem_addr0    <= addr_q + IDX_SIZE'(1);
              mem_write_en <= 1'b1;
              state        <= WR_ISSUE;
            end
          end
        end
        WR_RSP, ERR_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mem_d1_initiator.sv
// tb/tb_seq_mem_d1_initiator.sv - directed scoreboard bench for seq_mem_d1_initiator
module tb_seq_mem_d1_initiator;
  localparam int WIDTH = 32;
  localparam int SIZE  = 16;
  localparam int IDX   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [IDX-1:0]   cmd_addr = '0;
  logic [IDX-1:0]   cmd_len = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_last;
  logic             rsp_err;
  logic             busy;
  logic [IDX-1:0]   mem_addr0;
  logic             mem_read_en;
  logic             mem_write_en;
  logic [WIDTH-1:0] mem_in;
  logic [WIDTH-1:0] mem_out;
  logic             mem_read_done;
  logic             mem_write_done;

  seq_mem_d1_initiator #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
    .mem_addr0(mem_addr0), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_in(mem_in), .mem_out(mem_out),
    .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             err;
  } rsp_t;

  rsp_t           sb[$];
  logic [IDX-1:0] wr_log[$];
  int             rd_pulses = 0;
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  logic [WIDTH-1:0] model_mem [SIZE];

  always @(posedge clk) cyc <= cyc + 1;

  // Sequential memory: done one cycle after the strobe; a write clobbers out.
  logic             mem_init = 1'b1;
  logic [WIDTH-1:0] mem [SIZE];
  always @(posedge clk) begin
    mem_read_done  <= 1'b0;
    mem_write_done <= 1'b0;
    if (mem_init) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= 32'h1000 + i;
      mem_out <= '0;
    end else begin
      if (mem_read_en) begin
        mem_out       <= mem[mem_addr0];
        mem_read_done <= 1'b1;
      end
      if (mem_write_en) begin
        mem[mem_addr0] <= mem_in;
        mem_out        <= '0;
        mem_write_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe and response monitor.
  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_exclusive", 32'(mem_read_en && mem_write_en), 32'd0);
      if (mem_read_en) rd_pulses++;
      if (mem_write_en) wr_log.push_back(mem_addr0);
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          rsp_t r;
          r = sb.pop_front();
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_last", 32'(rsp_last), 32'(r.last));
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [IDX-1:0] addr,
                      input logic [IDX-1:0] len, input logic [WIDTH-1:0] data,
                      output int acc);
    logic ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp_valid(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("rsp_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic exp_read(input int addr, input int len);
    for (int i = 0; i <= len; i++)
      sb.push_back('{data: model_mem[addr+i], last: (i == len), err: 1'b0});
  endtask

  task automatic exp_wr_ok();
    sb.push_back('{data: '0, last: 1'b1, err: 1'b0});
  endtask

  task automatic exp_err();
    sb.push_back('{data: '0, last: 1'b1, err: 1'b1});
  endtask

  initial begin
    int   acc;
    logic ok;
    for (int i = 0; i < SIZE; i++) model_mem[i] = 32'h1000 + i;

    // Reset
    @(negedge clk);
    chk("rst_cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_flags", 32'({rsp_last, rsp_err, busy, mem_read_en, mem_write_en}), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_mem_addr0", 32'(mem_addr0), 32'd0);
    chk("rst_mem_in", mem_in, 32'd0);

    // Write addr 3 (len field must be ignored)
    wr_log.delete(); rd_pulses = 0;
    exp_wr_ok(); model_mem[3] = 32'hDEADBEEF;
    send(2'b01, 4'd3, 4'd9, 32'hDEADBEEF, acc);
    wait_done("write_done");
    chk("write_pulses", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) chk("write_addr", 32'(wr_log[0]), 32'd3);
    chk("write_no_reads", 32'(rd_pulses), 32'd0);

    // Read addr 3, latency check
    exp_read(3, 0);
    send(2'b00, 4'd3, 4'd0, '0, acc);
    @(negedge clk);
    chk("rd_issue_strobe", 32'(mem_read_en), 32'd1);
    chk("rd_issue_addr", 32'(mem_addr0), 32'd3);
    wait_rsp_valid(ok);
    chk("rd_latency", 32'(cyc - acc), 32'd2);
    wait_done("read3_done");

    // Fill 4..7, then read back
    wr_log.delete();
    exp_wr_ok();
    for (int i = 4; i < 8; i++) model_mem[i] = 32'h5A5A5A5A;
    send(2'b10, 4'd4, 4'd3, 32'h5A5A5A5A, acc);
    wait_done("fill_done");
    chk("fill_pulses", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk("fill_addr", 32'(wr_log[i]), 32'(4 + i));
    exp_read(4, 3);
    send(2'b00, 4'd4, 4'd3, '0, acc);
    wait_done("read_fill_done");

    // Backpressure on beat 0
    rsp_ready = 1'b0;
    exp_read(0, 1);
    send(2'b00, 4'd0, 4'd1, '0, acc);
    wait_rsp_valid(ok);
    rd_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, model_mem[0]);
    end
    chk("stall_no_issue", 32'(rd_pulses), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done("stall_done");

    // Rejected commands
    wr_log.delete(); rd_pulses = 0;
    exp_err();
    send(2'b00, 4'd14, 4'd2, '0, acc);
    wait_done("err_range_done");
    exp_err();
    send(2'b11, 4'd0, 4'd0, 32'h12345678, acc);
    wait_done("err_op_done");
    exp_err();
    send(2'b10, 4'd13, 4'd3, 32'h11111111, acc);
    wait_done("err_fill_done");
    chk("err_no_reads", 32'(rd_pulses), 32'd0);
    chk("err_no_writes", 32'(wr_log.size()), 32'd0);

    // Boundary: fill top word, full-array read
    wr_log.delete();
    exp_wr_ok(); model_mem[15] = 32'h0F0F0F0F;
    send(2'b10, 4'd15, 4'd0, 32'h0F0F0F0F, acc);
    wait_done("fill15_done");
    chk("fill15_pulses", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) chk("fill15_addr", 32'(wr_log[0]), 32'd15);
    rd_pulses = 0;
    exp_read(0, 15);
    send(2'b00, 4'd0, 4'd15, '0, acc);
    wait_done("read_all_done");
    chk("read_all_pulses", 32'(rd_pulses), 32'd16);

    // Reset in RD_WAIT of beat 1 of a 4-beat read
    exp_read(8, 3);
    send(2'b00, 4'd8, 4'd3, '0, acc);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mem_read_en && mem_addr0 == 4'd9) begin ok = 1'b1; break; end
    end
    chk("beat1_issue_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_flags", 32'({rsp_last, rsp_err, busy, mem_read_en, mem_write_en}), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_mem_addr0", 32'(mem_addr0), 32'd0);
    chk("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("midrst_quiet", 32'(rsp_valid), 32'd0);

    // Normal operation after reset
    exp_wr_ok(); model_mem[2] = 32'hCAFE0002;
    send(2'b01, 4'd2, 4'd0, 32'hCAFE0002, acc);
    wait_done("post_rst_write");
    exp_read(2, 0);
    send(2'b00, 4'd2, 4'd0, '0, acc);
    wait_done("post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mem_d1_initiator.md
Name: seq_mem_d1_initiator

Overview:
- Command-driven master for the single-port sequential memory interface: addr0, read_en, write_en, in, out, read_done, write_done.
- Accepts read, write and fill commands on a valid/ready channel and sequences them onto the memory port, one access at a time.
- Returns read data and write completions on a valid/ready response channel.
- Sits between control logic or an accelerator datapath and a seq_mem instance; it is the only driver of that memory's port.

Parameters:
- WIDTH, 32, data word width.
- SIZE, 16, number of memory words.
- IDX_SIZE, 4, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 read, 01 write, 10 fill, 11 reserved
- cmd_addr  in  IDX_SIZE  start address
- cmd_len  in  IDX_SIZE  beats minus one (read and fill only; ignored for write)
- cmd_data  in  WIDTH  write/fill data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  WIDTH  read word; 0 for write/fill/error responses
- rsp_last  out  1  final response of a command
- rsp_err  out  1  command rejected
- busy  out  1  high in any state other than IDLE
- mem_addr0  out  IDX_SIZE  memory address
- mem_read_en  out  1  memory read strobe
- mem_write_en  out  1  memory write strobe
- mem_in  out  WIDTH  memory write data
- mem_out  in  WIDTH  memory read data
- mem_read_done  in  1  memory read complete
- mem_write_done  in  1  memory write complete

Behaviour:
- Reset:
  - State returns to IDLE.
  - cmd_ready=0 during the reset cycle, then 1.
  - rsp_valid, rsp_last, rsp_err, busy, mem_read_en and mem_write_en are 0.
  - rsp_data, mem_addr0 and mem_in are 0.
  - Reset mid-command abandons the command with no response; memory contents are not restored.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_RSP, WR_ISSUE, WR_WAIT, WR_RSP, ERR_RSP.
- IDLE:
  - cmd_ready=1; all other states hold cmd_ready=0.
  - On accept, latch op, addr, len and data.
  - Compute end = cmd_addr + len in IDX_SIZE+1 bits, with len forced to 0 for write.
  - If op=11 or end >= SIZE, go to ERR_RSP and perform no memory access.
  - Otherwise read goes to RD_ISSUE; write and fill go to WR_ISSUE.
- RD_ISSUE: mem_read_en=1 for exactly one cycle with mem_addr0 = current address, then RD_WAIT.
- RD_WAIT:
  - Hold mem_addr0.
  - On mem_read_done, register mem_out into rsp_data, set rsp_last = (beat == len), go to RD_RSP.
- RD_RSP:
  - rsp_valid=1; rsp_data, rsp_last and rsp_err=0 held stable until rsp_ready.
  - On handshake: if last, go to IDLE; else increment address and beat, go to RD_ISSUE.
- WR_ISSUE: mem_write_en=1 for one cycle, mem_in = latched data, mem_addr0 = current address, then WR_WAIT.
- WR_WAIT: on mem_write_done, either increment and go to WR_ISSUE if more beats remain, or go to WR_RSP.
- WR_RSP: rsp_valid=1, rsp_data=0, rsp_last=1, rsp_err=0 until rsp_ready, then IDLE.
- ERR_RSP: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0 until rsp_ready, then IDLE.
- Invariants:
  - mem_read_en and mem_write_en are never high in the same cycle.
  - At most one memory access is outstanding.
  - mem_addr0 is stable from issue through done.
- mem_out is sampled only on mem_read_done, because the memory clobbers out after a write.
- mem_read_done and mem_write_done are ignored outside RD_WAIT and WR_WAIT respectively.
- Missing done: the block waits indefinitely; no timeout.
- Latency:
  - Command accepted at cycle T: issue at T+1, done at T+2, rsp_valid at T+3.
  - Read bursts take 3 cycles per beat plus rsp_ready stall cycles.
  - Fill takes 2 cycles per beat; the single response appears 1 cycle after the last done.
- Address never wraps: out-of-range bursts are rejected whole, so the highest address touched is SIZE-1.

Test Plan:
- Reset, then write addr=3, data=0xDEADBEEF -> exactly one mem_write_en pulse at addr 3; response rsp_last=1, rsp_err=0, rsp_data=0. Then read addr=3, len=0 -> rsp_data=0xDEADBEEF, rsp_last=1, rsp_valid first high 3 cycles after accept.
- Fill addr=4, len=3, data=0x5A5A5A5A, then read addr=4, len=3 -> four write pulses at addr 4..7; four read responses of 0x5A5A5A5A, rsp_last only on the 4th.
- Read addr=0, len=1 with rsp_ready held low 5 cycles on beat 0 -> rsp_data and rsp_valid stable for all 5 cycles; no mem_read_en issued until the handshake.
- Read addr=14, len=2 (end=16) and op=11 -> each gives one response with rsp_err=1, rsp_last=1, rsp_data=0; no mem strobes.
- Boundary: fill addr=15, len=0 accepted, touches addr 15 only; read addr=0, len=15 returns 16 beats.
- Assert reset in RD_WAIT of a 4-beat read -> outputs at reset values next cycle, no rsp_valid; the following command executes normally.
- Throughout all scenarios, an assertion checks mem_read_en and mem_write_en are never both high.
